// File: rtl/ascon_pack.sv
// ascon_pack: shared FSM state, round-count constants and round-constant helper for the round sequencer
package ascon_pack;
  localparam int P_CNT_W = 4;
  localparam int P_ROUNDS_MAX = 12;
  localparam int P_ROUNDS_HALF = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] rcst_f(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction
endpackage

// File: rtl/ascon_round_index.sv
// ascon_round_index: loadable saturating round counter with a first-round flag
module ascon_round_index
  import ascon_pack::*;
#(
  parameter int CNT_W = P_CNT_W,
  parameter int ROUNDS_MAX = P_ROUNDS_MAX,
  parameter int ROUNDS_HALF = P_ROUNDS_HALF
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             i_load,
  input  logic             i_load_sel,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_round,
  output logic             o_first
);
  logic [CNT_W-1:0] r_round;
  logic             r_first;
  // the index saturates at the last round; the FSM leaves RUN on that step
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      r_round <= '0;
      r_first <= 1'b0;
    end else if (i_load) begin
      r_round <= i_load_sel ? CNT_W'(ROUNDS_MAX - ROUNDS_HALF) : '0;
      r_first <= 1'b1;
    end else if (i_en) begin
      r_first <= 1'b0;
      if (r_round != CNT_W'(ROUNDS_MAX - 1)) r_round <= r_round + CNT_W'(1);
    end
  assign o_round = r_round;
  assign o_first = r_first;
endmodule

// File: rtl/ascon_round_sequencer.sv
// ascon_round_sequencer: issues p12/p6 round index, constant and enables to the permutation datapath
module ascon_round_sequencer
  import ascon_pack::*;
#(
  parameter int CNT_W = P_CNT_W,
  parameter int ROUNDS_MAX = P_ROUNDS_MAX,
  parameter int ROUNDS_HALF = P_ROUNDS_HALF
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             mode_p6_i,
  input  logic             hold_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] round_o,
  output logic [7:0]       rcst_o,
  output logic             perm_en_o,
  output logic             first_o,
  output logic             done_o
);
  state_t           r_state;
  logic             w_load;
  logic             w_first;
  logic [CNT_W-1:0] w_round;
  assign w_load = (r_state == IDLE) & start_i;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) r_state <= IDLE;
    else
      case (r_state)
        IDLE:    r_state <= start_i ? RUN : IDLE;
        RUN:     r_state <= (!hold_i && w_round == CNT_W'(ROUNDS_MAX - 1)) ? DONE : RUN;
        default: r_state <= IDLE;
      endcase
  ascon_round_index #(
    .CNT_W(CNT_W),
    .ROUNDS_MAX(ROUNDS_MAX),
    .ROUNDS_HALF(ROUNDS_HALF)
  ) u_index (
    .clock_i(clock_i),
    .resetb_i(resetb_i),
    .i_load(w_load),
    .i_load_sel(mode_p6_i),
    .i_en(perm_en_o),
    .o_round(w_round),
    .o_first(w_first)
  );
  assign ready_o   = r_state == IDLE;
  assign busy_o    = r_state == RUN;
  assign done_o    = r_state == DONE;
  assign perm_en_o = busy_o & ~hold_i;
  assign first_o   = w_first & perm_en_o;
  assign round_o   = w_round;
  assign rcst_o    = rcst_f(4'(w_round));
endmodule

// File: doc/ascon_round_sequencer.md
Name: ascon_round_sequencer

Overview:
- Control-side initiator for the permutation round datapath.
- Accepts a permutation request for p12 (rounds 0..11) or p6 (rounds 6..11). Drives the round index, the round constant, the state-register enable and the first-round input-select, with stall support.
- Pulses done when the last round has been applied.
- Sits between the top-level mode FSM (requester) and the permutation datapath (consumer).

Parameters:
- CNT_W, 4, width of the round index.
- ROUNDS_MAX, 12, total round count; the last round index is ROUNDS_MAX-1.
- ROUNDS_HALF, 6, round count for the short permutation; its start index is ROUNDS_MAX-ROUNDS_HALF.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  permutation request, sampled only while ready_o=1.
- mode_p6_i  in  1  0 = p12, 1 = p6. Latched with start_i.
- hold_i  in  1  stall. Freezes the round index and deasserts perm_en_o.
- ready_o  out  1  idle and able to accept start_i.
- busy_o  out  1  permutation in progress (RUN state).
- round_o  out  CNT_W  current round index.
- rcst_o  out  8  round constant for round_o.
- perm_en_o  out  1  state-register enable: one round is applied this cycle.
- first_o  out  1  selects the external input into the state register for the first round.
- done_o  out  1  one-cycle pulse after the last round.

Behaviour:
- Interface decision: reset resetb_i, asynchronous, active-low; clock clock_i.
- Reset values: state=IDLE, round index=0, mode latch=0, first flag=0.
  - Resulting outputs: ready_o=1, busy_o=0, perm_en_o=0, first_o=0, done_o=0, round_o=0, rcst_o=0xF0.
- FSM states: IDLE, RUN, DONE. All outputs are Moore except as noted below.
- IDLE:
  - ready_o=1.
  - If start_i=1: latch mode_p6_i, load the round index (0 for p12, 6 for p6), set the first flag, go to RUN.
  - Otherwise stay in IDLE; the round index holds its value.
- RUN:
  - busy_o=1.
  - perm_en_o = ~hold_i (combinational from hold_i).
  - first_o = first flag & ~hold_i.
  - If hold_i=1: round index, first flag and state are all frozen.
  - If hold_i=0 and round index < ROUNDS_MAX-1: increment the index, clear the first flag.
  - If hold_i=0 and round index = ROUNDS_MAX-1: go to DONE. The index holds at 11.
- DONE: done_o=1 for exactly one cycle, then unconditionally go to IDLE.
- start_i is ignored in RUN and DONE. It is not queued.
- Latency from the start_i cycle, with no stalls:
  - p12: 12 perm_en_o cycles, then done_o on cycle 13.
  - p6: 6 perm_en_o cycles, then done_o on cycle 7.
  - Each hold_i=1 cycle in RUN adds one cycle.
- Round constant: rcst_o = {(4'hF - round_o), round_o}, combinational from round_o.
  - Round 0 gives 0xF0, round 6 gives 0x96, round 11 gives 0x4B.
- Width rules:
  - The index never exceeds ROUNDS_MAX-1; there is no wrap in RUN.
  - Arithmetic is unsigned, CNT_W bits.
- hold_i in IDLE or DONE has no effect.
- Reset asserted mid-permutation returns immediately to the reset values. No done_o is emitted.
- mode_p6_i is don't-care outside the start_i acceptance cycle.

Decomposition:
- Shared package (ascon_pack) receives:
  - the FSM state enum;
  - ROUNDS_MAX/ROUNDS_HALF constants;
  - the round-constant function.
- One sub-module is natural: ascon_round_index, the loadable up-counter with its first flag.
  - Inputs: load, load_sel, en.
  - The FSM stays in the top module.

Test Plan:
- Reset then idle for 3 cycles -> ready_o=1, round_o=0, rcst_o=0xF0, perm_en_o=0, done_o=0.
- start_i=1 with mode_p6_i=0 -> round_o steps 0..11 over 12 cycles with perm_en_o=1.
  - first_o=1 only at round 0; rcst_o goes 0xF0..0x4B.
  - done_o pulses on cycle 13; ready_o=1 on cycle 14.
- start_i=1 with mode_p6_i=1 -> round_o steps 6..11 over 6 cycles.
  - first_o=1 at round 6 (rcst_o=0x96).
  - done_o on cycle 7.
- p12 run with hold_i=1 for 2 cycles at round 4 -> round_o stays 4 and perm_en_o=0 during the hold; done_o on cycle 15.
  - Same run with hold_i=1 at round 0 -> first_o=0 during the hold and reasserts when hold_i drops.
- start_i pulsed during RUN, and during DONE with mode_p6_i toggled -> ignored: the current sequence is unchanged and no second run starts.
- resetb_i=0 at round 8 of p12 -> outputs return to reset values immediately and no done_o is emitted.
  - A subsequent p6 start then behaves as in the p6 scenario.
